freq_gen_module: RTL and testbench

//  Programmable square-wave generator; the transmit-side counterpart of the frequency meter.

---
 rtl/freq_gen_module.sv | 117 +++++++++++
 tb/tb_freq_gen_module.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/freq_gen_module.sv
// NCO square-wave generator: clk_out at freq_set Hz from clk_base at freq_base Hz.
// Optional `FREQ_GEN_EDGE_CNT_EN adds a windowed rising-edge counter on edge_cnt.
module freq_gen_module #(
   parameter int W = 32
) (
   input  logic         clk_base,
   input  logic         aclr,
   input  logic [W-1:0] freq_base,
   input  logic [W-1:0] freq_set,
   input  logic         set_valid,
   output logic         set_ready,
   output logic         set_err,
   output logic         clk_out,
   output logic         running,
   output logic         period_end
`ifdef FREQ_GEN_EDGE_CNT_EN
   ,
   output logic [W-1:0] edge_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

   state_t         r_state;
   logic [W+1:0]   r_acc;
   logic [W-1:0]   r_f, r_b, r_pf, r_pb;
   logic           r_clk_out, r_set_err, r_period_end;

   logic           w_accept, w_bad, w_ok, w_tog, w_fall, w_apply;
   logic [W+1:0]   w_nxt;
   logic [W-1:0]   w_nf, w_nb;

   assign set_ready  = (r_state != PEND);
   assign running    = (r_state != IDLE);
   assign clk_out    = r_clk_out;
   assign set_err    = r_set_err;
   assign period_end = r_period_end;

   assign w_accept = set_valid & set_ready;
   assign w_bad    = (freq_base == '0) | ({freq_set, 1'b0} > {1'b0, freq_base});
   assign w_ok     = w_accept & ~w_bad;

   assign w_nxt  = r_acc + {1'b0, r_f, 1'b0};
   assign w_tog  = (r_state != IDLE) & (w_nxt >= {2'b00, r_b});
   assign w_fall = w_tog & r_clk_out;

   // New settings only land on a falling toggle so no runt high pulse is produced.
   assign w_apply = ((r_state == IDLE) & w_ok) |
                    ((r_state == RUN)  & w_ok & w_fall) |
                    ((r_state == PEND) & w_fall);
   assign w_nf    = (r_state == PEND) ? r_pf : freq_set;
   assign w_nb    = (r_state == PEND) ? r_pb : freq_base;

   always_ff @(posedge clk_base or posedge aclr) begin
      if (aclr) begin
         r_state      <= IDLE;
         r_acc        <= '0;
         r_f          <= '0;
         r_b          <= '0;
         r_pf         <= '0;
         r_pb         <= '0;
         r_clk_out    <= 1'b0;
         r_set_err    <= 1'b0;
         r_period_end <= 1'b0;
      end else begin
         r_set_err    <= w_accept & w_bad;
         r_period_end <= w_fall;
         if (w_tog) begin
            r_acc     <= w_nxt - {2'b00, r_b};
            r_clk_out <= ~r_clk_out;
         end else if (r_state != IDLE) begin
            r_acc <= w_nxt;
         end
         if (w_apply) begin
            r_f       <= w_nf;
            r_b       <= w_nb;
            r_acc     <= '0;
            r_clk_out <= 1'b0;
            r_state   <= (w_nf == '0) ? IDLE : RUN;
         end else if ((r_state == RUN) && w_ok) begin
            r_pf    <= freq_set;
            r_pb    <= freq_base;
            r_state <= PEND;
         end
      end
   end

`ifdef FREQ_GEN_EDGE_CNT_EN
   localparam logic [W-1:0] ONE = 1;
   logic [W-1:0] r_win, r_edges, r_edge_cnt;
   logic         w_rise;

   assign w_rise   = w_tog & ~r_clk_out;
   assign edge_cnt = r_edge_cnt;

   always_ff @(posedge clk_base or posedge aclr) begin
      if (aclr) begin
         r_win      <= '0;
         r_edges    <= '0;
         r_edge_cnt <= '0;
      end else if (w_apply) begin
         r_win   <= '0;
         r_edges <= '0;
      end else if (r_state != IDLE) begin
         if (r_win == r_b - ONE) begin
            r_edge_cnt <= r_edges + {{(W-1){1'b0}}, w_rise};
            r_win      <= '0;
            r_edges    <= '0;
         end else begin
            r_win   <= r_win + ONE;
            r_edges <= r_edges + {{(W-1){1'b0}}, w_rise};
         end
      end
   end
`endif

endmodule

// File: tb/tb_freq_gen_module.sv
// Directed bench for freq_gen_module: reset, NCO rates, rejects, pending/immediate apply, stop.
module tb_freq_gen_module;

   logic        clk_base = 1'b0;
   logic        aclr = 1'b1;
   logic [31:0] freq_base = '0;
   logic [31:0] freq_set = '0;
   logic        set_valid = 1'b0;
   logic        set_ready, set_err, clk_out, running, period_end;
`ifdef FREQ_GEN_EDGE_CNT_EN
   logic [31:0] edge_cnt;
`endif

   int checks = 0;
   int failures = 0;

   freq_gen_module #(.W(32)) dut (
      .clk_base   (clk_base),
      .aclr       (aclr),
      .freq_base  (freq_base),
      .freq_set   (freq_set),
      .set_valid  (set_valid),
      .set_ready  (set_ready),
      .set_err    (set_err),
      .clk_out    (clk_out),
      .running    (running),
      .period_end (period_end)
`ifdef FREQ_GEN_EDGE_CNT_EN
      ,
      .edge_cnt   (edge_cnt)
`endif
   );

   always #5 clk_base = ~clk_base;

   task automatic tick();
      @(posedge clk_base);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Ticks until clk_out reaches want; n is the number of edges taken.
   task automatic wait_clk(input logic want, input int maxc, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (clk_out !== want && n < maxc);
      chk("wait_clk_reached", clk_out, want);
   endtask

   task automatic req(input logic [31:0] b, input logic [31:0] f);
      freq_base = b;
      freq_set  = f;
      set_valid = 1'b1;
   endtask

   initial begin
      int n;
      int highs;
      int pat [14] = '{0,1,1,0,0,1,0, 0,1,1,0,0,1,0};

      // Reset state
      tick();
      tick();
      chk("rst_clk_out", clk_out, 1'b0);
      chk("rst_running", running, 1'b0);
      chk("rst_set_ready", set_ready, 1'b1);
      chk("rst_set_err", set_err, 1'b0);
      chk("rst_period_end", period_end, 1'b0);
      aclr = 1'b0;
      tick();

      // base=100 set=10: period 10, 5 high / 5 low
      req(100, 10);
      tick();
      set_valid = 1'b0;
      chk("t2_running", running, 1'b1);
      chk("t2_clk_low", clk_out, 1'b0);
      wait_clk(1'b1, 50, n);
      chk("t2_first_rise", n, 5);
      wait_clk(1'b0, 50, n);
      chk("t2_high_len", n, 5);
      chk("t2_period_end", period_end, 1'b1);
      tick();
      chk("t2_period_end_pulse", period_end, 1'b0);
      wait_clk(1'b1, 50, n);
      chk("t2_low_len", n, 4);
      wait_clk(1'b0, 50, n);
      chk("t2_high_len2", n, 5);

      // Change to 25 while high: pending until fall, then period 4
      wait_clk(1'b1, 50, n);
      chk("t5_rise", n, 5);
      req(100, 25);
      tick();
      chk("t5_ready_pend", set_ready, 1'b0);
      chk("t5_still_high", clk_out, 1'b1);
      wait_clk(1'b0, 50, n);
      set_valid = 1'b0;
      chk("t5_fall_after", n, 4);
      chk("t5_ready_back", set_ready, 1'b1);
      chk("t5_period_end", period_end, 1'b1);
      wait_clk(1'b1, 50, n);
      chk("t5_low_len", n, 2);
      wait_clk(1'b0, 50, n);
      chk("t5_high_len", n, 2);
      wait_clk(1'b1, 50, n);
      chk("t5_low_len2", n, 2);

      // Stop request: applied at next fall, then stays low
      req(100, 0);
      tick();
      set_valid = 1'b0;
      chk("t6_pend_running", running, 1'b1);
      chk("t6_pend_ready", set_ready, 1'b0);
      wait_clk(1'b0, 50, n);
      chk("t6_fall", n, 1);
      chk("t6_stopped", running, 1'b0);
      highs = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (clk_out !== 1'b0) highs++;
      end
      chk("t6_stays_low", highs, 0);

      // Rejects: base=0, then 2*set > base
      req(0, 0);
      tick();
      chk("t4_err_base0", set_err, 1'b1);
      req(100, 51);
      tick();
      set_valid = 1'b0;
      chk("t4_err_51", set_err, 1'b1);
      chk("t4_err_idle", running, 1'b0);
      tick();
      chk("t4_err_clear", set_err, 1'b0);
      chk("t4_err_clk", clk_out, 1'b0);

      // set=50: toggles every cycle
      req(100, 50);
      tick();
      set_valid = 1'b0;
      chk("t4_50_start", clk_out, 1'b0);
      tick();
      chk("t4_50_t1", clk_out, 1'b1);
      tick();
      chk("t4_50_t2", clk_out, 1'b0);
      chk("t4_50_pe", period_end, 1'b1);
      tick();
      chk("t4_50_t3", clk_out, 1'b1);
      req(100, 51);
      tick();
      set_valid = 1'b0;
      chk("t4_run_err", set_err, 1'b1);
      chk("t4_run_err_clk", clk_out, 1'b0);
      chk("t4_run_err_running", running, 1'b1);
      tick();
      chk("t4_run_err_clk2", clk_out, 1'b1);
      chk("t4_run_err_clear", set_err, 1'b0);

      // Request coinciding with falling toggle: applied immediately (base=7 set=2)
      req(7, 2);
      tick();
      set_valid = 1'b0;
      chk("t3_imm_clk", clk_out, 1'b0);
      chk("t3_imm_ready", set_ready, 1'b1);
      chk("t3_imm_pe", period_end, 1'b1);
      for (int i = 0; i < 14; i++) begin
         tick();
         chk($sformatf("t3_pat%0d", i), clk_out, pat[i]);
      end

      // Async reset mid-run with a pending request
      wait_clk(1'b1, 20, n);
      chk("t1_rise", n, 2);
      req(100, 10);
      tick();
      set_valid = 1'b0;
      chk("t1_pend", set_ready, 1'b0);
      chk("t1_high", clk_out, 1'b1);
      aclr = 1'b1;
      #1;
      chk("t1_rst_clk", clk_out, 1'b0);
      chk("t1_rst_running", running, 1'b0);
      chk("t1_rst_ready", set_ready, 1'b1);
      tick();
      aclr = 1'b0;
      highs = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (clk_out !== 1'b0) highs++;
      end
      chk("t1_no_glitch", highs, 0);
      chk("t1_discarded", running, 1'b0);

`ifdef FREQ_GEN_EDGE_CNT_EN
      req(1000, 10);
      tick();
      set_valid = 1'b0;
      repeat (2000) tick();
      chk("ec_edge_cnt", edge_cnt, 10);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
